// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester bus plus the shared multiplier's operand/start/answer port
interface mult_share_arbiter_if #(
  parameter int M_BITS = 12,
  parameter int N_BITS = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ*M_BITS-1:0] req_mpd;
  logic [NREQ*N_BITS-1:0] req_mpr;
  logic [NREQ-1:0] ack;
  logic [M_BITS+N_BITS-1:0] result;
  logic busy;
  logic [M_BITS-1:0] mult_mpd;
  logic [N_BITS-1:0] mult_mpr;
  logic mult_start;
  logic [M_BITS+N_BITS-1:0] mult_answer;
  modport slave (
    input req, req_mpd, req_mpr, mult_answer,
    output ack, result, busy, mult_mpd, mult_mpr, mult_start
  );
  modport master (
    output req, req_mpd, req_mpr, mult_answer,
    input ack, result, busy, mult_mpd, mult_mpr, mult_start
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one fixed-latency multiplier among NREQ requesters
module mult_share_arbiter #(
  parameter int M_BITS = 12,
  parameter int N_BITS = 8,
  parameter int NREQ = 4,
  parameter int MULT_LAT = 8
) (
  input logic clk,
  input logic rst_n,
  mult_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MULT_LAT + 1);
  localparam int RW = M_BITS + N_BITS;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, win, gnt, off;
  logic [PW:0] sum;
  logic [2*NREQ-1:0] dbl;
  logic [CW-1:0] cnt;
  logic cap;
  logic [M_BITS-1:0] mpd;
  logic [N_BITS-1:0] mpr;
  logic [RW-1:0] res;
  // rotate req so ptr sits at bit 0, take the lowest set bit, then rotate back
  always_comb begin
    dbl = {bus.req, bus.req} >> ptr;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (dbl[k]) off = PW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    gnt = PW'(sum >= (PW+1)'(NREQ) ? sum - (PW+1)'(NREQ) : sum);
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (|bus.req ? ISSUE : IDLE)
             : state == ISSUE ? (MULT_LAT == 1 ? RESP : WAIT)
             : state == WAIT  ? (cnt == CW'(1) ? RESP : WAIT)
             : IDLE;
  end
  assign cap = (state == ISSUE && MULT_LAT == 1) || (state == WAIT && cnt == CW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      win <= '0;
      cnt <= '0;
      mpd <= '0;
      mpr <= '0;
      res <= '0;
    end else begin
      if (state == IDLE && |bus.req) begin
        win <= gnt;
        mpd <= bus.req_mpd[gnt*M_BITS +: M_BITS];
        mpr <= bus.req_mpr[gnt*N_BITS +: N_BITS];
      end
      if (state == ISSUE) cnt <= CW'(MULT_LAT - 1);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (cap) res <= bus.mult_answer;
      if (state == RESP) ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
    end
  assign bus.mult_start = state == ISSUE || state == WAIT;
  assign bus.busy = state != IDLE;
  assign bus.ack = state == RESP ? NREQ'(1) << win : '0;
  assign bus.mult_mpd = mpd;
  assign bus.mult_mpr = mpr;
  assign bus.result = res;
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one booth_encode multiplier instance among NREQ requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the multiplier's level-sensitive start over a fixed latency, then returns the product to the winner with a one-cycle ack.
- Sits between client datapaths and the single multiplier so the multiplier need not be replicated.

Parameters:
M_BITS, 12, multiplicand width (mpd)
N_BITS, 8, multiplier width (mpr)
NREQ, 4, number of requesters (>=2)
MULT_LAT, 8, cycles mult_start must be high before mult_answer is valid (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  NREQ  req[i] high = requester i wants a multiply
req_mpd  in  NREQ*M_BITS  slice i = [i*M_BITS +: M_BITS], operand of requester i
req_mpr  in  NREQ*N_BITS  slice i = [i*N_BITS +: N_BITS]
ack  out  NREQ  one-hot, 1-cycle pulse; result valid for requester i
result  out  M_BITS+N_BITS  product, valid while any ack bit is high
busy  out  1  high from grant until ack cycle inclusive
mult_mpd  out  M_BITS  to multiplier mpd
mult_mpr  out  N_BITS  to multiplier mpr
mult_start  out  1  to multiplier start (level)
mult_answer  in  M_BITS+N_BITS  from multiplier answer

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - ack = 0, result = 0, busy = 0, mult_mpd = 0, mult_mpr = 0, mult_start = 0.
  - Round-robin pointer ptr = 0; latency counter = 0.
  - An in-flight operation is discarded; no ack is issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise, grant g = the first set bit of req scanning ptr, ptr+1, … mod NREQ.
  - Register the operand slices of g into mult_mpd and mult_mpr, record g, go to ISSUE.
- ISSUE:
  - mult_start = 1, busy = 1.
  - Load counter = MULT_LAT-1.
  - If MULT_LAT == 1, go to RESP; else go to WAIT.
- WAIT:
  - mult_start = 1; counter decrements each cycle.
  - When counter reaches 1 (this is the MULT_LAT-th start-high cycle), go to RESP.
- Answer capture: at the edge ending the MULT_LAT-th start-high cycle, mult_answer is registered into result.
- RESP:
  - mult_start = 0; ack[g] = 1 for exactly one cycle.
  - result holds the captured answer.
  - ptr = (g+1) mod NREQ; go to IDLE.
- result holds its value until the next capture; it is only meaningful during ack.
- Operands: mult_mpd and mult_mpr are held stable from ISSUE through RESP.
  - Changes on req_mpd/req_mpr after grant are ignored.
  - The arbiter does not interpret signedness; result is mult_answer passed through unchanged.
- mult_start is guaranteed low for at least 2 cycles (RESP, IDLE) between operations, so the multiplier always sees a fresh rising edge.
- Latency: req sampled in IDLE at cycle 0 → mult_start high cycles 1..MULT_LAT → ack at cycle MULT_LAT+1.
- Throughput: one operation per MULT_LAT+2 cycles maximum.
- Requester protocol:
  - Hold req[i] high until ack[i].
  - Deassert req[i] at the edge ending the ack cycle.
  - req is sampled only in IDLE, so a req still high in the cycle after ack is a new request (served after others under round-robin).
  - Dropping req[i] after grant does not cancel the operation; ack[i] still pulses.
- Simultaneous requests: served strictly in round-robin order from ptr. No requester waits more than NREQ-1 operations.
- Reset released mid-stream resumes in IDLE with ptr = 0.

Test Plan:
1. Single request: req=4'b0001, slice0 mpd=190, mpr=120 → mult_start high cycles 1–8; ack=4'b0001 at cycle 9; result=22800; busy high cycles 1–9.
2. Simultaneous: req=4'b1111, distinct operands (i+1)*10 × (i+2) → acks in order 0,1,2,3, spaced 10 cycles, each result correct; ptr returns to 0.
3. Fairness: req0 re-asserted continuously, req2 held → grant order 0,2,0,2; neither is starved.
4. Reset mid-op: rst_n low during WAIT cycle 5 → mult_start, busy, ack go 0 immediately; no ack. After release, a held req0 is re-served with ack 9 cycles later.
5. Operand change after grant: req1 granted with mpd=3, mpr=5; slice1 changed to 7 during WAIT → mult_mpd stays 3; result=15.
6. Back-to-back/start gap: two queued requests → mult_start low for exactly 2 cycles between bursts; the second ack arrives 10 cycles after the first.
